// File: rtl/bram_arb_64.sv
// Two-port (instruction/data) arbiter in front of a single-port 64-bit BRAM.
// Fixed priority with a starvation guard; define BRAM_ARB_RR_EN for round-robin.
module bram_arb_64 #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [13:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [63:0] i_rdata,
    input  logic        d_req,
    input  logic [7:0]  d_we,
    input  logic [13:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        ram_en,
    output logic [7:0]  ram_we,
    output logic [13:0] ram_addr,
    output logic [63:0] ram_wdata,
    input  logic [63:0] ram_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_INST,
        TAG_DATA
    } tag_e;

    tag_e        tag_q, tag_d;
    logic        i_win, d_win;
    logic [63:0] i_rdata_q, d_rdata_q;

`ifdef BRAM_ARB_RR_EN
    // Pointer holds the last winner: 0 = instruction, 1 = data.
    logic last_q, last_d;

    always_comb begin
        i_win = 1'b0;
        d_win = 1'b0;
        if (i_req && d_req) begin
            i_win = last_q;
            d_win = !last_q;
        end else begin
            i_win = i_req;
            d_win = d_req;
        end
    end

    always_comb begin
        last_d = last_q;
        if (i_gnt) last_d = 1'b0;
        else if (d_gnt) last_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b0;
        else     last_q <= last_d;
    end
`else
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        i_win = i_req && (!d_req || (cnt_q >= SMAX));
        d_win = d_req && !i_win;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (i_gnt) cnt_d = '0;
        else if (i_req && (cnt_q < SMAX)) cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign i_gnt = i_win && !rst;
    assign d_gnt = d_win && !rst;

    always_comb begin
        ram_en    = i_gnt || d_gnt;
        ram_we    = d_gnt ? d_we : 8'h00;
        ram_addr  = d_gnt ? d_addr : i_addr;
        ram_wdata = d_wdata;
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (i_gnt) tag_d = TAG_INST;
        else if (d_gnt) tag_d = TAG_DATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q     <= TAG_NONE;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            tag_q <= tag_d;
            if (tag_q == TAG_INST) i_rdata_q <= ram_rdata;
            if (tag_q == TAG_DATA) d_rdata_q <= ram_rdata;
        end
    end

    // RAM data arrives the cycle after the grant; hold it afterwards.
    assign i_rvalid = (tag_q == TAG_INST);
    assign d_rvalid = (tag_q == TAG_DATA);
    assign i_rdata  = i_rvalid ? ram_rdata : i_rdata_q;
    assign d_rdata  = d_rvalid ? ram_rdata : d_rdata_q;

endmodule

// File: tb/tb_bram_arb_64.sv
// Directed bench for bram_arb_64 with a behavioural byte-write BRAM.
// Build with BRAM_ARB_RR_EN to check the round-robin variant.
module tb_bram_arb_64;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [13:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [63:0] i_rdata;
    logic        d_req;
    logic [7:0]  d_we;
    logic [13:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        ram_en;
    logic [7:0]  ram_we;
    logic [13:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;

    int n_run  = 0;
    int n_fail = 0;

    logic [63:0] mem [0:16383];

    always #5 clk = ~clk;

    bram_arb_64 #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Write-first BRAM: the read port returns the merged word.
    always @(posedge clk) begin : ram_model
        logic [63:0] w;
        if (ram_en) begin
            w = mem[ram_addr];
            for (int b = 0; b < 8; b++)
                if (ram_we[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
            mem[ram_addr] = w;
            ram_rdata <= w;
        end
    end

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    initial begin
        logic exp_i, exp_d;
        for (int a = 0; a < 16384; a++) mem[a] = '0;
        mem[14'h0010] = 64'h1122334455667788;
        ram_rdata = '0;

        // Reset state with both requests asserted.
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1;
        i_addr = 14'h0010; d_addr = 14'h0020;
        d_we = 8'h00; d_wdata = '0;
        #2;
        check("rst_i_gnt", 64'(i_gnt), 64'd0);
        check("rst_d_gnt", 64'(d_gnt), 64'd0);
        check("rst_ram_en", 64'(ram_en), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_i_rvalid", 64'(i_rvalid), 64'd0);
        check("rst_d_rvalid", 64'(d_rvalid), 64'd0);
        check("rst_i_rdata", i_rdata, 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;

        // Single instruction read.
        @(negedge clk);
        i_req = 1'b1; i_addr = 14'h0010;
        #1;
        check("rd_i_gnt", 64'(i_gnt), 64'd1);
        check("rd_d_gnt", 64'(d_gnt), 64'd0);
        check("rd_ram_en", 64'(ram_en), 64'd1);
        check("rd_ram_we", 64'(ram_we), 64'd0);
        check("rd_ram_addr", 64'(ram_addr), 64'h10);
        @(negedge clk);
        i_req = 1'b0;
        check("rd_i_rvalid", 64'(i_rvalid), 64'd1);
        check("rd_i_rdata", i_rdata, 64'h1122334455667788);
        check("rd_d_rvalid", 64'(d_rvalid), 64'd0);
        @(negedge clk);
        check("rd_i_rvalid_off", 64'(i_rvalid), 64'd0);
        check("rd_i_rdata_hold", i_rdata, 64'h1122334455667788);
        check("idle_ram_en", 64'(ram_en), 64'd0);

        // Byte write to 0x0020 then read it back.
        d_req = 1'b1; d_we = 8'h01; d_addr = 14'h0020;
        d_wdata = 64'h00000000000000FF;
        #1;
        check("wr_d_gnt", 64'(d_gnt), 64'd1);
        check("wr_ram_we", 64'(ram_we), 64'h01);
        check("wr_ram_addr", 64'(ram_addr), 64'h20);
        check("wr_ram_wdata", ram_wdata, 64'hFF);
        @(negedge clk);
        d_we = 8'h00; d_wdata = '0;
        check("wr_d_rvalid", 64'(d_rvalid), 64'd1);
        check("wr_d_rdata", d_rdata, 64'hFF);
        #1;
        check("rb_d_gnt", 64'(d_gnt), 64'd1);
        check("rb_ram_we", 64'(ram_we), 64'd0);
        @(negedge clk);
        d_req = 1'b0;
        check("rb_d_rvalid", 64'(d_rvalid), 64'd1);
        check("rb_d_rdata", d_rdata, 64'h00000000000000FF);
        check("rb_i_rdata_hold", i_rdata, 64'h1122334455667788);
        @(negedge clk);
        check("rb_d_rvalid_off", 64'(d_rvalid), 64'd0);
        check("rb_d_rdata_hold", d_rdata, 64'hFF);

        // Withdrawn request is dropped: no response afterwards.
        @(negedge clk);
        check("drop_i_rvalid", 64'(i_rvalid), 64'd0);
        check("drop_d_rvalid", 64'(d_rvalid), 64'd0);

        // Conflict from a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b1; d_we = 8'h00;
        i_addr = 14'h0010; d_addr = 14'h0020;
        for (int k = 0; k < 10; k++) begin
`ifdef BRAM_ARB_RR_EN
            exp_i = (k % 2) == 1;
`else
            exp_i = (k % 5) == 4;
`endif
            exp_d = !exp_i;
            #1;
            check($sformatf("cf_i_gnt%0d", k), 64'(i_gnt), 64'(exp_i));
            check($sformatf("cf_d_gnt%0d", k), 64'(d_gnt), 64'(exp_d));
            check($sformatf("cf_both%0d", k), 64'(i_gnt && d_gnt), 64'd0);
            @(negedge clk);
            check($sformatf("cf_i_rv%0d", k), 64'(i_rvalid), 64'(exp_i));
            check($sformatf("cf_d_rv%0d", k), 64'(d_rvalid), 64'(exp_d));
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // Reset pulsed in the cycle after i_gnt drops the response.
        i_req = 1'b1; i_addr = 14'h0010;
        #1;
        check("mr_i_gnt", 64'(i_gnt), 64'd1);
        @(posedge clk);
        #1;
        i_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("mr_i_rvalid", 64'(i_rvalid), 64'd0);
        check("mr_i_rdata", i_rdata, 64'd0);
        check("mr_d_rdata", d_rdata, 64'd0);
        check("mr_ram_en", 64'(ram_en), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mr_i_rvalid_post", 64'(i_rvalid), 64'd0);
        i_req = 1'b1; i_addr = 14'h0020;
        #1;
        check("mr_next_gnt", 64'(i_gnt), 64'd1);
        @(negedge clk);
        i_req = 1'b0;
        check("mr_next_rvalid", 64'(i_rvalid), 64'd1);
        check("mr_next_rdata", i_rdata, 64'hFF);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
